// File: rtl/imem_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : imem_pkg
// Purpose : Shared sizes and state encoding for the instruction-memory loader
//           and the instruction memory's run-time write port.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package imem_pkg;

   localparam int IMEM_BITSIZE = 32;
   localparam int IMEM_DEPTH   = 64;
   localparam int IMEM_ADDRW   = 6;

   // Loader state encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEN   = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_LEN   = ST_LEN,
      S_DATA  = ST_DATA,
      S_WRITE = ST_WRITE,
      S_ERR   = ST_ERR
   } ldr_state_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : word_assembler
// Purpose : 8-to-WIDTH bit shift register assembling big-endian words.
//           The first byte shifted in ends up in the top byte of dout.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset
//           clr    - synchronous clear of data and byte counter
//           en     - shift din in this cycle
//           din    - input byte
//           dout   - assembled word
//           full   - this cycle's shift completes a word (4th byte)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module word_assembler #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [7:0]       din,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       cnt_q, cnt_d;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr) begin
         data_d = '0;
         cnt_d  = 2'd0;
      end else if (en) begin
         data_d = {data_q[WIDTH-9:0], din};
         // Wraps 3 -> 0 naturally on the last byte of a word
         cnt_d  = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout = data_q;
   assign full = en && !clr && (cnt_q == 2'd3);

endmodule : word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : imem_loader
// Purpose : Loads the instruction memory from a byte stream: a length byte N
//           followed by N big-endian words, each written through a
//           single-cycle write strobe. Holds the CPU while loading.
// Ports   : Clk       - clock
//           Rst_n     - asynchronous active-low reset
//           Start     - load request, honoured only when idle
//           InData    - stream byte
//           InValid   - InData valid
//           InReady   - loader accepts a byte this cycle
//           MemWrEn   - instruction memory write strobe
//           MemWrAddr - word address of write
//           MemWrData - word to write
//           CpuHold   - load in progress, CPU must stall
//           Done      - sticky, last load completed
//           Error     - sticky, length byte out of range
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module imem_loader
   import imem_pkg::*;
#(
   parameter int BITSIZE = IMEM_BITSIZE,
   parameter int DEPTH   = IMEM_DEPTH,
   parameter int ADDRW   = IMEM_ADDRW
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               Start,
   input  logic [7:0]         InData,
   input  logic               InValid,
   output logic               InReady,
   output logic               MemWrEn,
   output logic [ADDRW-1:0]   MemWrAddr,
   output logic [BITSIZE-1:0] MemWrData,
   output logic               CpuHold,
   output logic               Done,
   output logic               Error
);

   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   ldr_state_t       state_q, state_d;
   // One extra bit so that a full-depth load reaches DEPTH without wrapping
   logic [ADDRW:0]   word_cnt_q, word_cnt_d;
   logic [ADDRW:0]   n_q, n_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             asm_clr;
   logic             asm_en;
   logic             asm_full;
   logic             accept;
   logic [ADDRW:0]   word_cnt_inc;
   logic [BITSIZE-1:0] asm_word;

   word_assembler #(
      .WIDTH (BITSIZE)
   ) u_word_assembler (
      .clk   (Clk),
      .rst_n (Rst_n),
      .clr   (asm_clr),
      .en    (asm_en),
      .din   (InData),
      .dout  (asm_word),
      .full  (asm_full)
   );

   assign accept       = InValid && InReady;
   assign word_cnt_inc = word_cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      n_d        = n_q;
      done_d     = done_q;
      error_d    = error_q;
      asm_clr    = 1'b0;
      asm_en     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d    = S_LEN;
               done_d     = 1'b0;
               error_d    = 1'b0;
               word_cnt_d = '0;
               asm_clr    = 1'b1;
            end
         end

         S_LEN: begin
            if (accept) begin
               if (InData == 8'd0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else if (InData > DEPTH_B) begin
                  // Raised on entry so Error is already high during ERR
                  state_d = S_ERR;
                  error_d = 1'b1;
               end else begin
                  state_d = S_DATA;
                  n_d     = InData[ADDRW:0];
               end
            end
         end

         S_DATA: begin
            asm_en = accept;
            if (asm_full) begin
               state_d = S_WRITE;
            end
         end

         S_WRITE: begin
            word_cnt_d = word_cnt_inc;
            asm_clr    = 1'b1;
            if (word_cnt_inc == n_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_DATA;
            end
         end

         S_ERR: begin
            error_d = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= S_IDLE;
         word_cnt_q <= '0;
         n_q        <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         n_q        <= n_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   // Handshake and strobe outputs decode registered state only
   assign InReady   = (state_q == S_LEN) || (state_q == S_DATA);
   assign MemWrEn   = (state_q == S_WRITE);
   assign CpuHold   = (state_q != S_IDLE);
   assign MemWrAddr = word_cnt_q[ADDRW-1:0];
   assign MemWrData = asm_word;
   assign Done      = done_q;
   assign Error     = error_q;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_imem_loader
// Purpose : Self-checking bench for imem_loader. Expected writes come from a
//           queue of stream words: word i must land at address i.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_imem_loader;
   import imem_pkg::*;

   logic                    Clk     = 1'b0;
   logic                    Rst_n   = 1'b0;
   logic                    Start   = 1'b0;
   logic [7:0]              InData  = 8'h00;
   logic                    InValid = 1'b0;
   logic                    InReady;
   logic                    MemWrEn;
   logic [IMEM_ADDRW-1:0]   MemWrAddr;
   logic [IMEM_BITSIZE-1:0] MemWrData;
   logic                    CpuHold;
   logic                    Done;
   logic                    Error;

   int tests = 0;
   int fails = 0;

   logic [31:0]           exp_words[$];
   logic [IMEM_ADDRW-1:0] got_addr[$];
   logic [31:0]           got_data[$];

   typedef struct {
      logic [7:0] len;
      int         gap;
      logic       exp_done;
      logic       exp_err;
      int         exp_n;
   } vec_t;

   vec_t vecs[6];

   always #5 Clk = ~Clk;

   imem_loader dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Start     (Start),
      .InData    (InData),
      .InValid   (InValid),
      .InReady   (InReady),
      .MemWrEn   (MemWrEn),
      .MemWrAddr (MemWrAddr),
      .MemWrData (MemWrData),
      .CpuHold   (CpuHold),
      .Done      (Done),
      .Error     (Error)
   );

   // Record every write strobe, sampled mid-cycle
   always @(negedge Clk) begin
      if (MemWrEn) begin
         got_addr.push_back(MemWrAddr);
         got_data.push_back(MemWrData);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int cnt;
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
         @(negedge Clk);
         InValid = 1'b0;
         InData  = 8'($urandom);
      end
      @(negedge Clk);
      InData  = b;
      InValid = 1'b1;
      cnt     = 0;
      while (!InReady && cnt < 50) begin
         @(negedge Clk);
         cnt++;
      end
      check("inready_wait", (cnt < 50) ? 32'd1 : 32'd0, 32'd1);
      @(posedge Clk);
      #1;
      InValid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int k = 0; k < 4; k++) begin
         send_byte(8'(w >> (24 - 8 * k)), maxgap);
      end
   endtask

   task automatic wait_idle();
      int cnt;
      cnt = 0;
      @(negedge Clk);
      while (CpuHold && cnt < 40) begin
         @(negedge Clk);
         cnt++;
      end
      check("idle_wait_cpuhold", {31'd0, CpuHold}, 32'd0);
   endtask

   task automatic pulse_start();
      @(negedge Clk);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   task automatic clear_capture();
      got_addr.delete();
      got_data.delete();
   endtask

   // Full load of the words currently in exp_words with length byte len
   task automatic run_load(input logic [7:0] len, input int maxgap);
      clear_capture();
      pulse_start();
      check("start_inready", {31'd0, InReady}, 32'd1);
      check("start_cpuhold", {31'd0, CpuHold}, 32'd1);
      check("start_clr_done", {31'd0, Done}, 32'd0);
      check("start_clr_error", {31'd0, Error}, 32'd0);
      send_byte(len, maxgap);
      foreach (exp_words[i]) send_word(exp_words[i], maxgap);
      wait_idle();
   endtask

   task automatic compare_writes(input string tag);
      check($sformatf("%s_nwrites", tag), 32'(got_addr.size()), 32'(exp_words.size()));
      for (int i = 0; i < got_addr.size() && i < exp_words.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(i));
         check($sformatf("%s_data%0d", tag, i), got_data[i], exp_words[i]);
      end
   endtask

   initial begin
      logic [7:0] rlen;

      // ---------------- reset values ----------------
      #1;
      check("rst_inready", {31'd0, InReady}, 32'd0);
      check("rst_memwren", {31'd0, MemWrEn}, 32'd0);
      check("rst_addr", 32'(MemWrAddr), 32'd0);
      check("rst_data", MemWrData, 32'd0);
      check("rst_cpuhold", {31'd0, CpuHold}, 32'd0);
      check("rst_done", {31'd0, Done}, 32'd0);
      check("rst_error", {31'd0, Error}, 32'd0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;

      // ---------------- two fixed words with timing ----------------
      exp_words = '{32'hF2800022, 32'h8B01004A};
      clear_capture();
      check("idle_inready", {31'd0, InReady}, 32'd0);
      pulse_start();
      check("two_inready_after_start", {31'd0, InReady}, 32'd1);
      send_byte(8'h02, 0);
      send_word(exp_words[0], 0);
      send_word(exp_words[1], 0);
      @(negedge Clk);
      check("two_last_wren", {31'd0, MemWrEn}, 32'd1);
      check("two_last_inready", {31'd0, InReady}, 32'd0);
      check("two_last_cpuhold", {31'd0, CpuHold}, 32'd1);
      @(negedge Clk);
      check("two_after_wren", {31'd0, MemWrEn}, 32'd0);
      check("two_after_cpuhold", {31'd0, CpuHold}, 32'd0);
      check("two_after_done", {31'd0, Done}, 32'd1);
      check("two_after_error", {31'd0, Error}, 32'd0);
      compare_writes("two");

      // ---------------- table-driven lengths ----------------
      vecs[0] = '{8'd0,   0, 1'b1, 1'b0, 0};
      vecs[1] = '{8'd1,   0, 1'b1, 1'b0, 1};
      vecs[2] = '{8'd65,  0, 1'b0, 1'b1, 0};
      vecs[3] = '{8'd3,   2, 1'b1, 1'b0, 3};
      vecs[4] = '{8'd255, 1, 1'b0, 1'b1, 0};
      vecs[5] = '{8'd5,   3, 1'b1, 1'b0, 5};
      for (int v = 0; v < 6; v++) begin
         exp_words.delete();
         for (int i = 0; i < vecs[v].exp_n; i++) exp_words.push_back($urandom);
         run_load(vecs[v].len, vecs[v].gap);
         check($sformatf("vec%0d_done", v), {31'd0, Done}, {31'd0, vecs[v].exp_done});
         check($sformatf("vec%0d_error", v), {31'd0, Error}, {31'd0, vecs[v].exp_err});
         check($sformatf("vec%0d_inready", v), {31'd0, InReady}, 32'd0);
         compare_writes($sformatf("vec%0d", v));
      end

      // ---------------- full depth with random stalls ----------------
      exp_words.delete();
      for (int i = 0; i < 64; i++) exp_words.push_back($urandom);
      run_load(8'd64, 3);
      check("full_done", {31'd0, Done}, 32'd1);
      check("full_error", {31'd0, Error}, 32'd0);
      compare_writes("full");
      repeat (3) @(negedge Clk);
      check("full_no_extra_writes", 32'(got_addr.size()), 32'd64);

      // ---------------- random loads against reference rules ----------------
      for (int r = 0; r < 5; r++) begin
         rlen = 8'($urandom_range(0, 80));
         exp_words.delete();
         if (rlen <= 8'd64) begin
            for (int i = 0; i < int'(rlen); i++) exp_words.push_back($urandom);
         end
         run_load(rlen, 2);
         check($sformatf("rnd%0d_done", r), {31'd0, Done}, {31'd0, (rlen <= 8'd64)});
         check($sformatf("rnd%0d_error", r), {31'd0, Error}, {31'd0, (rlen > 8'd64)});
         compare_writes($sformatf("rnd%0d", r));
      end

      // ---------------- reset in the middle of a word ----------------
      clear_capture();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      @(negedge Clk);
      Rst_n = 1'b0;
      #1;
      check("mid_rst_inready", {31'd0, InReady}, 32'd0);
      check("mid_rst_memwren", {31'd0, MemWrEn}, 32'd0);
      check("mid_rst_addr", 32'(MemWrAddr), 32'd0);
      check("mid_rst_data", MemWrData, 32'd0);
      check("mid_rst_cpuhold", {31'd0, CpuHold}, 32'd0);
      check("mid_rst_done", {31'd0, Done}, 32'd0);
      check("mid_rst_error", {31'd0, Error}, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      check("mid_rst_no_writes", 32'(got_addr.size()), 32'd0);
      exp_words = '{32'hCAFEF00D};
      run_load(8'd1, 0);
      check("after_rst_done", {31'd0, Done}, 32'd1);
      compare_writes("after_rst");

      // ---------------- InValid in IDLE, Start while busy ----------------
      @(negedge Clk);
      InData  = 8'hAA;
      InValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check($sformatf("idle_valid_inready%0d", i), {31'd0, InReady}, 32'd0);
         check($sformatf("idle_valid_cpuhold%0d", i), {31'd0, CpuHold}, 32'd0);
      end
      InValid = 1'b0;
      clear_capture();
      exp_words = '{32'h01234567};
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      send_byte(8'h23, 0);
      pulse_start();
      check("busy_start_cpuhold", {31'd0, CpuHold}, 32'd1);
      send_byte(8'h45, 0);
      send_byte(8'h67, 0);
      wait_idle();
      check("busy_done", {31'd0, Done}, 32'd1);
      check("busy_error", {31'd0, Error}, 32'd0);
      compare_writes("busy");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the instruction memory at run time instead of relying on hard-coded initial contents. It accepts a length byte followed by big-endian 32-bit instruction words over a valid/ready byte interface. It assembles each word and drives a single-cycle write port into the instruction memory, holding the CPU in reset-hold until the load completes. It sits between the board-level serial/debug front end and the instruction memory write port.

## Interface
- BITSIZE, 32, instruction word width
- DEPTH, 64, instruction memory depth in words
- ADDRW, 6, write address width (log2 DEPTH)

- Clk  input  1  clock, all state updates on rising edge
- Rst_n  input  1  asynchronous, active-low reset
- Start  input  1  one-cycle load request; honoured only in IDLE
- InData  input  8  stream byte
- InValid  input  1  InData valid
- InReady  output  1  loader accepts a byte this cycle
- MemWrEn  output  1  instruction memory write strobe, one cycle per word
- MemWrAddr  output  ADDRW  word address of write
- MemWrData  output  BITSIZE  word to write
- CpuHold  output  1  high while a load is in progress; CPU/PC must stall
- Done  output  1  sticky: last load completed; cleared by next Start
- Error  output  1  sticky: length byte out of range; cleared by next Start

## Operation
- States: IDLE, LEN, DATA, WRITE, ERR.
- IDLE: InReady=0. Start → LEN, clear Done/Error, word counter=0, byte counter=0.
- LEN: InReady=1. On accept, latch N=InData. N==0 → IDLE with Done=1, no writes. N>DEPTH → ERR. Otherwise → DATA.
- DATA: InReady=1. Each accepted byte shifts into the assembly register, MSB first (first byte → bits 31:24). Byte counter increments 0..3. On the 4th accept → WRITE.
- WRITE: InReady=0, MemWrEn=1, MemWrAddr=word counter, MemWrData=assembled word. Word counter then increments and byte counter resets. If the new count equals N → IDLE with Done=1; else → DATA.
- ERR: Error=1, no writes, InReady=0; → IDLE next cycle (Error stays high).
- CpuHold=1 in LEN, DATA, WRITE and ERR; 0 in IDLE.
- Start outside IDLE is ignored. InValid in IDLE is ignored; no byte is consumed.
- Counters: byte counter 2 bits; word counter ADDRW+1 bits so N=DEPTH terminates without wrapping. MemWrAddr is its low ADDRW bits.

## Timing
- Reset values: InReady=0, MemWrEn=0, MemWrAddr=0, MemWrData=0, CpuHold=0, Done=0, Error=0, state=IDLE.
- InReady, MemWrEn and CpuHold are decoded from registered state only, with no combinational path from inputs.
- A byte transfers on a rising edge where InValid&InReady.
- Start at edge T → LEN at T+1, so InReady rises after T.
- The 4th byte of a word accepted at edge T → MemWrEn high for exactly the cycle after T.
- Minimum throughput is 5 cycles per word: 4 accept cycles plus 1 write cycle.
- Last write cycle ends at edge T → Done=1 and CpuHold=0 from T onward.
- Producer stalls (InValid low) may last any length. State, counters and the partial word hold unchanged.
- Rst_n assertion mid-load immediately forces all reset values. Memory words already written stay written, and no partial word is written. Done stays 0.

## Structure
- Shared package imem_pkg:
  - state encoding localparams (IDLE, LEN, DATA, WRITE, ERR)
  - IMEM_BITSIZE=32, IMEM_DEPTH=64, IMEM_ADDRW=6
  - these are also used by the instruction memory's new write port
- One sub-module, word_assembler: 8→32 shift register with a 2-bit byte counter and a `full` flag, cleared by a `clr` input.
- The FSM, word counter and output decode stay in imem_loader.

## Test plan
- Load two words: Start, then bytes 0x02, F2 80 00 22, 8B 01 00 4A. Required: MemWrEn pulses with (addr 0, 0xF2800022) and (addr 1, 0x8B01004A); Done=1; CpuHold falls after the second write.
- Length 0: Start, byte 0x00. Required: no MemWrEn, Done=1 one cycle after acceptance, Error=0.
- Length 65: Start, byte 0x41. Required: Error=1, no MemWrEn, CpuHold returns to 0, and a later Start clears Error.
- Full depth: N=64 (0x40), 256 data bytes with random InValid gaps. Required: exactly 64 writes to addrs 0..63, words matching the stream, counter does not wrap, Done=1.
- Reset mid-word: N=1, 2 data bytes, assert Rst_n low. Required: all outputs at reset values, no MemWrEn; a following full load writes the new word correctly to addr 0.
- Start while busy and InValid in IDLE: pulse Start during DATA and drive InValid before Start. Required: load unaffected, no byte consumed in IDLE, InReady=0 in IDLE.
